// File: rtl/parking_occupancy_counter.sv
// rtl/parking_occupancy_counter.sv - saturating lot occupancy counter with BCD, status and sticky error flags
// Optional macro PARKING_EDGE_DETECT_EN: count rising edges of car_in/car_out instead of high levels.
module parking_occupancy_counter #(
  parameter int CAPACITY   = 20,
  parameter int CNT_W      = 7,
  parameter int WARN_LEVEL = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_in,
  input  logic             car_out,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] free_spaces,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             full,
  output logic             empty,
  output logic             near_full,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] WARN_C = CNT_W'(WARN_LEVEL);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free_q, free_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             near_q, near_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ev_in, ev_out;

`ifdef PARKING_EDGE_DETECT_EN
  logic in_prev_q, in_prev_d;
  logic out_prev_q, out_prev_d;

  always_comb begin
    in_prev_d  = car_in;
    out_prev_d = car_out;
    ev_in      = car_in & ~in_prev_q;
    ev_out     = car_out & ~out_prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_prev_q  <= 1'b0;
      out_prev_q <= 1'b0;
    end else begin
      in_prev_q  <= in_prev_d;
      out_prev_q <= out_prev_d;
    end
  end
`else
  always_comb begin
    ev_in  = car_in;
    ev_out = car_out;
  end
`endif

  // Simultaneous entry and exit cancel out, so neither moves the count nor raises an error.
  always_comb begin
    count_d = count_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;
    if (ev_in && !ev_out) begin
      if (count_q != CAP_C) begin
        count_d = count_q + 1'b1;
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ev_out && !ev_in) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end else begin
        unf_d = 1'b1;
      end
    end
    free_d  = CAP_C - count_d;
    full_d  = (count_d == CAP_C);
    empty_d = (count_d == '0);
    near_d  = (count_d >= WARN_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      free_q  <= CAP_C;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      near_q  <= (WARN_LEVEL == 0);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      free_q  <= free_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      near_q  <= near_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count         = count_q;
  assign free_spaces   = free_q;
  assign bcd_tens      = tens_q;
  assign bcd_ones      = ones_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign near_full     = near_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// tb/tb_parking_occupancy_counter.sv - table-driven bench for parking_occupancy_counter
module tb_parking_occupancy_counter;

  logic       clk = 1'b0;
  logic       reset, car_in, car_out, err_clr;
  logic [6:0] count, free_spaces;
  logic [3:0] bcd_tens, bcd_ones;
  logic       full, empty, near_full, overflow_err, underflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parking_occupancy_counter #(.CAPACITY(20), .CNT_W(7), .WARN_LEVEL(18)) dut (
    .clk(clk), .reset(reset), .car_in(car_in), .car_out(car_out), .err_clr(err_clr),
    .count(count), .free_spaces(free_spaces), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .full(full), .empty(empty), .near_full(near_full),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  typedef struct {
    logic ci, co, ec, rst;
    int   cnt;
    logic ovf, unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic ci, logic co, logic ec, logic rst, int cnt, logic ovf, logic unf);
    vec_t v;
    v.ci = ci; v.co = co; v.ec = ec; v.rst = rst; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(int idx, int cnt, logic ovf, logic unf);
    chk("count", idx, int'(count), cnt);
    chk("free_spaces", idx, int'(free_spaces), 20 - cnt);
    chk("bcd_tens", idx, int'(bcd_tens), cnt / 10);
    chk("bcd_ones", idx, int'(bcd_ones), cnt % 10);
    chk("full", idx, int'(full), int'(cnt == 20));
    chk("empty", idx, int'(empty), int'(cnt == 0));
    chk("near_full", idx, int'(near_full), int'(cnt >= 18));
    chk("overflow_err", idx, int'(overflow_err), int'(ovf));
    chk("underflow_err", idx, int'(underflow_err), int'(unf));
  endtask

  task automatic drive(logic ci, logic co, logic ec, logic rst);
    car_in = ci; car_out = co; err_clr = ec; reset = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; car_in = 1'b0; car_out = 1'b0; err_clr = 1'b0;

    add(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) add(1, 0, 0, 0, i, 0, 0);
    add(0, 1, 0, 0, 9, 0, 0);
    for (int i = 10; i <= 20; i++) add(1, 0, 0, 0, i, 0, 0);
    add(1, 0, 0, 0, 20, 1, 0);
    add(0, 0, 1, 0, 20, 0, 0);
    add(1, 1, 0, 0, 20, 0, 0);
    for (int i = 19; i >= 0; i--) add(0, 1, 0, 0, i, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) add(1, 0, 0, 0, i, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) add(1, 0, 0, 0, i, 0, 0);
    add(1, 0, 1, 0, 20, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0);

    // each vector is a one-cycle pulse followed by an idle cycle, valid in both decode modes
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ci, vecs[i].co, vecs[i].ec, vecs[i].rst);
      check_all(i, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
      drive(0, 0, 0, 0);
    end

    // car_in held high for four cycles
    car_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    car_in = 1'b0;
    @(posedge clk);
    #1;
`ifdef PARKING_EDGE_DETECT_EN
    check_all(1000, 1, 0, 0);
`else
    check_all(1000, 4, 0, 0);
`endif

    // latency: outputs unchanged before the edge that samples the pulse
    car_in = 1'b1;
    @(negedge clk);
`ifdef PARKING_EDGE_DETECT_EN
    chk("latency_before", 1001, int'(count), 1);
`else
    chk("latency_before", 1001, int'(count), 4);
`endif
    @(posedge clk);
    #1;
    car_in = 1'b0;
`ifdef PARKING_EDGE_DETECT_EN
    chk("latency_after", 1002, int'(count), 2);
`else
    chk("latency_after", 1002, int'(count), 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_counter.md
Name: parking_occupancy_counter

Overview:
- Downstream consumer of the parking-lot entry/exit sequencing FSM.
- Takes its single-cycle "car entered" and "car exited" pulses and tracks lot occupancy up to a fixed capacity.
- Produces binary and two-digit BCD occupancy, free-space count, status flags and sticky overflow/underflow error flags for display and barrier logic.

Parameters:
- CAPACITY, 20: number of spaces; legal range 1..99.
- CNT_W, 7: width of count and free_spaces; must satisfy 2**CNT_W > CAPACITY.
- WARN_LEVEL, 18: near_full asserts when count >= WARN_LEVEL; legal range 0..CAPACITY.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- car_in  input  1  entry event pulse from the sequencing FSM.
- car_out  input  1  exit event pulse from the sequencing FSM.
- err_clr  input  1  clears both sticky error flags.
- count  output  CNT_W  current occupancy, binary.
- free_spaces  output  CNT_W  CAPACITY - count.
- bcd_tens  output  4  tens digit of count, BCD.
- bcd_ones  output  4  ones digit of count, BCD.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- near_full  output  1  count >= WARN_LEVEL.
- overflow_err  output  1  sticky; an entry was attempted while full.
- underflow_err  output  1  sticky; an exit was attempted while empty.

Behaviour:
- Reset values, applied on a clock edge with reset=1:
  - count=0, free_spaces=CAPACITY, bcd_tens=0, bcd_ones=0.
  - empty=1, full=0, near_full=(WARN_LEVEL==0).
  - overflow_err=0, underflow_err=0.
- Reset takes priority over all inputs in the same cycle.
- All outputs are registered. An event sampled at edge N is reflected on every output after edge N (latency 1).
- All outputs are mutually consistent in every cycle. Flags and BCD digits are computed from the next count value, not delayed by a further cycle.
- Event decode per cycle, without EDGE_DETECT_EN: every cycle with the input high is one event.
  - in=1, out=0:
    - If count<CAPACITY, count+1.
    - Otherwise count holds and overflow_err is set.
  - in=0, out=1:
    - If count>0, count-1.
    - Otherwise count holds and underflow_err is set.
  - in=1, out=1: net zero; count holds and no error is raised, even when full or empty.
  - in=0, out=0: hold.
- BCD digits are held in dedicated registers, updated in step with count. No combinational binary-to-BCD conversion on the outputs.
  - Increment: ones 9 -> 0 with tens+1.
  - Decrement: ones 0 -> 9 with tens-1.
  - Digits always equal count in decimal.
- free_spaces is registered and updated with count. It never underflows, because count never exceeds CAPACITY.
- Sticky errors:
  - Once set, a flag stays set until err_clr or reset.
  - err_clr=1 clears both flags at the next edge.
  - If an error condition occurs in the same cycle as err_clr, the flag is set (set wins).
- count never wraps. It saturates at 0 and at CAPACITY.

Optional Feature:
- Macro: PARKING_EDGE_DETECT_EN.
- When defined:
  - car_in and car_out pass through registered rising-edge detectors.
  - An input held high for multiple cycles counts as one event.
  - Detector registers clear on reset.
  - Latency from input rise to output change becomes 1 cycle from the rising edge sample. A rising edge sampled at edge N updates outputs after edge N, using the previous-sample register.
- When undefined: inputs are used level-per-cycle as described in Behaviour.

Test Plan:
- Reset, then idle 5 cycles -> count=0, empty=1, full=0, free_spaces=20, bcd=0/0, both errors 0.
- 10 single-cycle car_in pulses -> count=10, bcd_tens=1, bcd_ones=0, free_spaces=10. One car_out -> count=9, bcd 0/9.
- Fill to 20 -> full=1, near_full=1 (asserted at 18). One more car_in -> count stays 20, overflow_err=1. err_clr -> overflow_err=0 next cycle.
- From count=0: car_out -> underflow_err=1, count=0. car_out and err_clr in the same cycle -> underflow_err stays 1.
- count=20: car_in and car_out asserted together -> count=20, no error. At count=0, both together -> count=0, no error.
- Reset asserted at count=15 with car_in high -> all outputs return to reset values next cycle.
- With PARKING_EDGE_DETECT_EN: car_in held high 4 cycles -> count increases by exactly 1.
